// File: rtl/joy_cond_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : joy_cond_pkg
//  Description : Shared types, direction indices and rotation helper for the
//                joystick conditioner.
//  Revision    : 1.0 - initial release
// ============================================================================
package joy_cond_pkg;

    // Bit positions inside one 4-bit lane {up,down,left,right}
    localparam int DIR_R = 0;
    localparam int DIR_L = 1;
    localparam int DIR_D = 2;
    localparam int DIR_U = 3;

    // Encoding of the 4-way axis record
    localparam logic AXIS_V = 1'b0;
    localparam logic AXIS_H = 1'b1;

    typedef enum logic [1:0] {
        SOCD_LAST    = 2'd0,
        SOCD_NEUTRAL = 2'd1,
        SOCD_FIRST   = 2'd2,
        SOCD_RSVD    = 2'd3
    } socd_mode_t;

    typedef enum logic [1:0] {
        ROT_0   = 2'd0,
        ROT_90  = 2'd1,
        ROT_180 = 2'd2,
        ROT_270 = 2'd3
    } rot_t;

    // Remap one lane for a rotated screen; each output direction is taken
    // from the physical direction listed on the right-hand side.
    function automatic logic [3:0] rotate(input logic [3:0] d, input rot_t r);
        logic [3:0] o;
        o = d;
        case (r)
            ROT_90: begin
                o[DIR_U] = d[DIR_L];
                o[DIR_D] = d[DIR_R];
                o[DIR_L] = d[DIR_D];
                o[DIR_R] = d[DIR_U];
            end
            ROT_180: begin
                o[DIR_U] = d[DIR_D];
                o[DIR_D] = d[DIR_U];
                o[DIR_L] = d[DIR_R];
                o[DIR_R] = d[DIR_L];
            end
            ROT_270: begin
                o[DIR_U] = d[DIR_R];
                o[DIR_D] = d[DIR_L];
                o[DIR_L] = d[DIR_U];
                o[DIR_R] = d[DIR_D];
            end
            default: o = d;
        endcase
        return o;
    endfunction

endpackage : joy_cond_pkg
`default_nettype wire

// File: rtl/joy_cond_lane.sv
`default_nettype none
// ============================================================================
//  Module      : joy_cond_lane
//  Description : One player lane: synchroniser, edge detect, per-axis SOCD
//                resolution, optional 4-way restriction and output register.
//  Revision    : 1.0 - initial release
// ============================================================================
module joy_cond_lane
    import joy_cond_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic [1:0] socd_mode,
    input  logic       four_way,
    input  logic [3:0] dir_in,
    output logic [3:0] dir_out
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
    logic [3:0]                  prev_q, prev_d;
    logic [1:0]                  last_h_q, last_h_d;
    logic [1:0]                  last_v_q, last_v_d;
    logic [1:0]                  first_h_q, first_h_d;
    logic [1:0]                  first_v_q, first_v_d;
    logic                        h_act_q, h_act_d;   // post-SOCD h was non-zero
    logic                        v_act_q, v_act_d;   // post-SOCD v was non-zero
    logic                        axis_q, axis_d;
    logic [3:0]                  out_q, out_d;

    // ------------------------------------------------------------------
    // Combinational intermediates
    // ------------------------------------------------------------------
    socd_mode_t mode;
    logic [3:0] held;
    logic [3:0] rise;
    logic [1:0] h_held, v_held, h_rise, v_rise;
    logic [1:0] h_res, v_res;
    logic       h_nz, v_nz;

    assign mode   = socd_mode_t'(socd_mode);
    assign held   = sync_q[SYNC_STAGES-1];
    assign rise   = held & ~prev_q;
    assign h_held = {held[DIR_L], held[DIR_R]};
    assign v_held = {held[DIR_U], held[DIR_D]};
    assign h_rise = {rise[DIR_L], rise[DIR_R]};
    assign v_rise = {rise[DIR_U], rise[DIR_D]};

    // Most recent single press; a simultaneous double press forgets it.
    function automatic logic [1:0] next_last(input logic [1:0] rise2,
                                             input logic [1:0] last2);
        logic [1:0] r;
        r = last2;
        if (rise2 == 2'b11)
            r = 2'b00;
        else if (rise2 != 2'b00)
            r = rise2;
        return r;
    endfunction

    // Direction that was held alone before the pair closed.
    function automatic logic [1:0] next_first(input logic [1:0] held2,
                                              input logic [1:0] first2);
        logic [1:0] r;
        r = first2;
        if (held2 == 2'b00)
            r = 2'b00;
        else if (held2 != 2'b11)
            r = held2;
        return r;
    endfunction

    // Only an opposing pair is resolved; anything else passes through.
    function automatic logic [1:0] resolve(input logic [1:0] held2,
                                           input logic [1:0] last2,
                                           input logic [1:0] first2,
                                           input socd_mode_t m);
        logic [1:0] r;
        r = held2;
        if (held2 == 2'b11) begin
            case (m)
                SOCD_NEUTRAL: r = 2'b00;
                SOCD_FIRST:   r = first2;
                default:      r = last2;
            endcase
        end
        return r;
    endfunction

    // Synchroniser shift chain plus one history stage for edge detection
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = dir_in;
        for (int k = 1; k < SYNC_STAGES; k++)
            sync_d[k] = sync_q[k-1];
        prev_d = held;
    end

    // Per-axis SOCD records and resolution (uses this cycle's updated records)
    always_comb begin
        last_h_d  = next_last(h_rise, last_h_q);
        last_v_d  = next_last(v_rise, last_v_q);
        first_h_d = next_first(h_held, first_h_q);
        first_v_d = next_first(v_held, first_v_q);
        h_res     = resolve(h_held, last_h_d, first_h_d, mode);
        v_res     = resolve(v_held, last_v_d, first_v_d, mode);
    end

    // Axis tracking and optional diagonal suppression feeding the output flop
    always_comb begin
        h_nz    = |h_res;
        v_nz    = |v_res;
        h_act_d = h_nz;
        v_act_d = v_nz;
        axis_d  = axis_q;
        if (h_nz && !h_act_q && !(v_nz && !v_act_q))
            axis_d = AXIS_H;
        else if (v_nz && !v_act_q && !(h_nz && !h_act_q))
            axis_d = AXIS_V;

        out_d = {v_res, h_res};
        if (four_way && h_nz && v_nz) begin
            if (axis_d == AXIS_H)
                out_d = {2'b00, h_res};
            else
                out_d = {v_res, 2'b00};
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= '0;
            prev_q    <= '0;
            last_h_q  <= '0;
            last_v_q  <= '0;
            first_h_q <= '0;
            first_v_q <= '0;
            h_act_q   <= 1'b0;
            v_act_q   <= 1'b0;
            axis_q    <= AXIS_V;
            out_q     <= '0;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            last_h_q  <= last_h_d;
            last_v_q  <= last_v_d;
            first_h_q <= first_h_d;
            first_v_q <= first_v_d;
            h_act_q   <= h_act_d;
            v_act_q   <= v_act_d;
            axis_q    <= axis_d;
            out_q     <= out_d;
        end
    end

    assign dir_out = out_q;

endmodule : joy_cond_lane
`default_nettype wire

// File: rtl/joy_cond.sv
`default_nettype none
// ============================================================================
//  Module      : joy_cond
//  Description : Multi-player joystick conditioner. Rotates each lane's raw
//                directions and hands them to an independent lane pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
module joy_cond
    import joy_cond_pkg::*;
#(
    parameter int PLAYERS     = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic [1:0]             rot,
    input  logic [1:0]             socd_mode,
    input  logic                   four_way,
    input  logic [4*PLAYERS-1:0]   joy_in,
    output logic [4*PLAYERS-1:0]   joy_out
);

    rot_t rot_sel;
    assign rot_sel = rot_t'(rot);

    generate
        for (genvar p = 0; p < PLAYERS; p++) begin : g_lane
            logic [3:0] rot_dir;

            // Rotation is applied ahead of the synchroniser
            assign rot_dir = rotate(joy_in[4*p +: 4], rot_sel);

            joy_cond_lane #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_lane (
                .clk_sys   (clk_sys),
                .reset_n   (reset_n),
                .socd_mode (socd_mode),
                .four_way  (four_way),
                .dir_in    (rot_dir),
                .dir_out   (joy_out[4*p +: 4])
            );
        end
    endgenerate

endmodule : joy_cond
`default_nettype wire

// File: tb/tb_joy_cond.sv
`default_nettype none
// ============================================================================
//  Module      : tb_joy_cond
//  Description : Self-checking bench for joy_cond (2 players, 2 sync stages).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_joy_cond;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] rot = 2'd0;
    logic [1:0] socd_mode = 2'd0;
    logic       four_way = 1'b0;
    logic [7:0] joy_in = 8'h00;
    logic [7:0] joy_out;

    int n_total = 0;
    int n_pass  = 0;

    joy_cond #(
        .PLAYERS     (2),
        .SYNC_STAGES (2)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .rot       (rot),
        .socd_mode (socd_mode),
        .four_way  (four_way),
        .joy_in    (joy_in),
        .joy_out   (joy_out)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [1:0] rot;
        logic [1:0] mode;
        logic       fw;
        logic [7:0] joy;
        logic [7:0] exp;
    } vec_t;

    localparam int NVEC = 32;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: joy_out=%02h expected=%02h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic neg(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    initial begin
        // {rot, mode, four_way, joy_in, expected joy_out after settling}
        vecs[0]  = '{2'd0, 2'd0, 1'b0, 8'h00, 8'h00};
        vecs[1]  = '{2'd0, 2'd1, 1'b0, 8'h1C, 8'h10}; // neutral U+D, lane1 R
        vecs[2]  = '{2'd0, 2'd1, 1'b0, 8'h00, 8'h00};
        vecs[3]  = '{2'd0, 2'd2, 1'b0, 8'hC4, 8'h04}; // first-wins: D first
        vecs[4]  = '{2'd0, 2'd2, 1'b0, 8'hCC, 8'h04}; // lane1 U+D together -> 0
        vecs[5]  = '{2'd0, 2'd2, 1'b0, 8'h00, 8'h00};
        vecs[6]  = '{2'd0, 2'd0, 1'b0, 8'h03, 8'h00}; // L+R same cycle
        vecs[7]  = '{2'd0, 2'd0, 1'b0, 8'h03, 8'h00};
        vecs[8]  = '{2'd0, 2'd0, 1'b0, 8'h01, 8'h01};
        vecs[9]  = '{2'd0, 2'd0, 1'b0, 8'h00, 8'h00};
        vecs[10] = '{2'd0, 2'd3, 1'b0, 8'h01, 8'h01}; // reserved mode = last-wins
        vecs[11] = '{2'd0, 2'd3, 1'b0, 8'h03, 8'h02};
        vecs[12] = '{2'd0, 2'd3, 1'b0, 8'h00, 8'h00};
        vecs[13] = '{2'd0, 2'd0, 1'b0, 8'h02, 8'h02};
        vecs[14] = '{2'd0, 2'd0, 1'b0, 8'h03, 8'h01}; // R newest
        vecs[15] = '{2'd0, 2'd2, 1'b0, 8'h03, 8'h02}; // first record kept L
        vecs[16] = '{2'd0, 2'd1, 1'b0, 8'h03, 8'h00};
        vecs[17] = '{2'd0, 2'd0, 1'b0, 8'h03, 8'h01}; // last record kept R
        vecs[18] = '{2'd0, 2'd0, 1'b0, 8'h00, 8'h00};
        vecs[19] = '{2'd0, 2'd0, 1'b1, 8'h08, 8'h08}; // 4-way: U
        vecs[20] = '{2'd0, 2'd0, 1'b1, 8'h09, 8'h01}; // add R -> R
        vecs[21] = '{2'd0, 2'd0, 1'b1, 8'h08, 8'h08}; // release R -> U
        vecs[22] = '{2'd0, 2'd0, 1'b1, 8'h09, 8'h01};
        vecs[23] = '{2'd0, 2'd0, 1'b0, 8'h09, 8'h09}; // 8-way: diagonal passes
        vecs[24] = '{2'd0, 2'd0, 1'b0, 8'h00, 8'h00};
        vecs[25] = '{2'd0, 2'd0, 1'b1, 8'h09, 8'h01}; // both new: axis stays h
        vecs[26] = '{2'd0, 2'd0, 1'b1, 8'h00, 8'h00};
        vecs[27] = '{2'd1, 2'd0, 1'b0, 8'h20, 8'h80}; // rot90 lane1 L -> U
        vecs[28] = '{2'd1, 2'd0, 1'b0, 8'h08, 8'h01}; // rot90 lane0 U -> R
        vecs[29] = '{2'd2, 2'd0, 1'b0, 8'h12, 8'h21}; // rot180 swaps L/R
        vecs[30] = '{2'd3, 2'd0, 1'b0, 8'h48, 8'h12}; // rot270 U->L, D->R
        vecs[31] = '{2'd0, 2'd0, 1'b0, 8'h00, 8'h00};

        // --- Reset state and first-press latency ---
        neg(3);
        check("reset_state", joy_out, 8'h00);
        reset_n = 1'b1;
        neg(2);
        joy_in = 8'h08;
        neg(1);
        check("latency_c1", joy_out, 8'h00);
        neg(1);
        check("latency_c2", joy_out, 8'h00);
        neg(1);
        check("latency_c3", joy_out, 8'h08);

        // --- Asynchronous reset mid-hold, then re-appearance ---
        #2 reset_n = 1'b0;
        #1 check("async_reset", joy_out, 8'h00);
        neg(1);
        check("reset_held", joy_out, 8'h00);
        reset_n = 1'b1;
        neg(2);
        check("post_reset_c2", joy_out, 8'h00);
        neg(1);
        check("post_reset_c3", joy_out, 8'h08);
        joy_in = 8'h00;
        neg(4);

        // --- Table-driven steady-state vectors ---
        for (int i = 0; i < NVEC; i++) begin
            rot       = vecs[i].rot;
            socd_mode = vecs[i].mode;
            four_way  = vecs[i].fw;
            joy_in    = vecs[i].joy;
            neg(4);
            check($sformatf("vec%0d", i), joy_out, vecs[i].exp);
        end

        // --- Last-wins hand-over timing: R, then L two cycles later ---
        rot = 2'd0; socd_mode = 2'd0; four_way = 1'b0;
        joy_in = 8'h01;
        neg(2);
        joy_in = 8'h03;
        neg(1);
        check("lw_r_out", joy_out, 8'h01);
        neg(1);
        check("lw_before_l", joy_out, 8'h01);
        neg(1);
        check("lw_l_wins", joy_out, 8'h02);
        joy_in = 8'h01;
        neg(2);
        check("lw_rel_c2", joy_out, 8'h02);
        neg(1);
        check("lw_rel_c3", joy_out, 8'h01);
        joy_in = 8'h00;
        neg(4);
        check("final_idle", joy_out, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Runaway guard: the sequence above is fixed-length, this should never fire
    initial begin
        #100000;
        $display("FAIL watchdog: joy_out=%02h expected=finish", joy_out);
        $fatal(1, "timeout");
    end

endmodule : tb_joy_cond
`default_nettype wire
